// File: rtl/glm_dma_write_arbiter.sv
// glm_dma_write_arbiter
// Shares the single DMA write channel (control, write data, write ack) between
// NUM_REQ write-back requesters. Arbitration is round-robin per whole
// transaction: the winner holds the channel from grant until every line of its
// transaction has been acknowledged, so acks always route to exactly one owner.
//
// Optional feature macro: GLM_WRARB_PERF_EN
//   When defined, adds per-requester performance counters perf_grants and
//   perf_wait. When undefined, those ports and counters do not exist.

module glm_dma_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int CLADDR_W = 42,
    parameter int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*CLADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]   req_len,
    output logic [NUM_REQ-1:0]      req_grant,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ*512-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]      req_walmostfull,
    output logic [NUM_REQ-1:0]      req_wack,
    output logic                    dma_start,
    output logic [CLADDR_W-1:0]     dma_addr,
    output logic [31:0]             dma_len,
    input  logic                    dma_active,
    output logic                    dma_tx_we,
    output logic [511:0]            dma_tx_wdata,
    input  logic                    dma_tx_walmostfull,
    input  logic                    dma_rx_wvalid,
    output logic                    busy,
    output logic [OWN_W-1:0]        owner,
    output logic                    err_stray_we
`ifdef GLM_WRARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]   perf_grants,
    output logic [NUM_REQ*32-1:0]   perf_wait
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_STREAM  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              state;
    logic [OWN_W-1:0]    rr;
    logic [31:0]         sent;
    logic [31:0]         acked;

    logic                any_req;
    logic [OWN_W-1:0]    pick;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [CLADDR_W-1:0] pick_addr;
    logic [31:0]         pick_len;
    logic [NUM_REQ-1:0]  owner_mask;
    logic                owner_we;
    logic [511:0]        owner_wdata;
    logic                stray_we;
    logic                fwd_ok;
    logic [OWN_W-1:0]    owner_next;

    // First requester with valid set, scanning start, start+1, ... with wrap.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [OWN_W-1:0]   start);
        int   idx;
        logic found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                rr_pick = OWN_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // Arbitration choice, owner-side data muxing and stray-strobe detection.
    always_comb begin
        any_req    = |req_valid;
        pick       = rr_pick(req_valid, rr);
        pick_mask  = '0;
        pick_mask[pick] = 1'b1;
        pick_addr  = req_addr[pick*CLADDR_W +: CLADDR_W];
        pick_len   = req_len[pick*32 +: 32];
        owner_mask = '0;
        owner_mask[owner] = 1'b1;
        owner_we    = req_we[owner];
        owner_wdata = req_wdata[owner*512 +: 512];
        stray_we    = |(req_we & ~owner_mask);
        fwd_ok      = (state == ST_STREAM) && owner_we && (sent != dma_len);
        owner_next  = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

    // Backpressure and ack routing: only the owner sees the DMA signals, and
    // only while streaming; everyone else is held off.
    always_comb begin
        req_walmostfull = '1;
        req_wack        = '0;
        if (state == ST_STREAM) begin
            req_walmostfull[owner] = dma_tx_walmostfull;
            req_wack[owner]        = dma_rx_wvalid;
        end
    end

    // Transaction FSM: arbitration, grant/start pulses, line and ack counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr           <= '0;
            owner        <= '0;
            sent         <= '0;
            acked        <= '0;
            req_grant    <= '0;
            dma_start    <= 1'b0;
            dma_addr     <= '0;
            dma_len      <= '0;
            busy         <= 1'b0;
            dma_tx_we    <= 1'b0;
            err_stray_we <= 1'b0;
        end else begin
            req_grant <= '0;
            dma_start <= 1'b0;
            dma_tx_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req && !dma_active) begin
                        owner     <= pick;
                        dma_addr  <= pick_addr;
                        dma_len   <= pick_len;
                        sent      <= '0;
                        acked     <= '0;
                        req_grant <= pick_mask;
                        dma_start <= (pick_len != 32'd0);
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Zero-length requests are acknowledged by the grant alone.
                    if (dma_len == 32'd0) begin
                        rr    <= owner_next;
                        state <= ST_IDLE;
                    end else begin
                        busy  <= 1'b1;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (fwd_ok) begin
                        dma_tx_we <= 1'b1;
                        sent      <= sent + 32'd1;
                    end
                    if ((owner_we && (sent == dma_len)) || stray_we) begin
                        err_stray_we <= 1'b1;
                    end
                    if (dma_rx_wvalid) begin
                        acked <= acked + 32'd1;
                        if (acked + 32'd1 == dma_len) begin
                            busy  <= 1'b0;
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    rr    <= owner_next;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write data stage: one-cycle registered copy of the owner's line.
    always_ff @(posedge clk) begin
        if (fwd_ok) begin
            dma_tx_wdata <= owner_wdata;
        end
    end

`ifdef GLM_WRARB_PERF_EN
    // Free-running per-requester grant and wait-cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants <= '0;
            perf_wait   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((state == ST_GRANT) && (owner == OWN_W'(i))) begin
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
                end
                if (req_valid[i] && !((state != ST_IDLE) && (owner == OWN_W'(i)))) begin
                    perf_wait[i*32 +: 32] <= perf_wait[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_glm_dma_write_arbiter.sv
// Directed self-checking bench for glm_dma_write_arbiter (NUM_REQ=2).

module tb_glm_dma_write_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int CLADDR_W = 42;
    localparam int OWN_W    = 1;

    logic                        clk;
    logic                        reset;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*CLADDR_W-1:0] req_addr;
    logic [NUM_REQ*32-1:0]       req_len;
    logic [NUM_REQ-1:0]          req_grant;
    logic [NUM_REQ-1:0]          req_we;
    logic [NUM_REQ*512-1:0]      req_wdata;
    logic [NUM_REQ-1:0]          req_walmostfull;
    logic [NUM_REQ-1:0]          req_wack;
    logic                        dma_start;
    logic [CLADDR_W-1:0]         dma_addr;
    logic [31:0]                 dma_len;
    logic                        dma_active;
    logic                        dma_tx_we;
    logic [511:0]                dma_tx_wdata;
    logic                        dma_tx_walmostfull;
    logic                        dma_rx_wvalid;
    logic                        busy;
    logic [OWN_W-1:0]            owner;
    logic                        err_stray_we;
`ifdef GLM_WRARB_PERF_EN
    logic [NUM_REQ*32-1:0]       perf_grants;
    logic [NUM_REQ*32-1:0]       perf_wait;
`endif

    glm_dma_write_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .CLADDR_W (CLADDR_W),
        .OWN_W    (OWN_W)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_len            (req_len),
        .req_grant          (req_grant),
        .req_we             (req_we),
        .req_wdata          (req_wdata),
        .req_walmostfull    (req_walmostfull),
        .req_wack           (req_wack),
        .dma_start          (dma_start),
        .dma_addr           (dma_addr),
        .dma_len            (dma_len),
        .dma_active         (dma_active),
        .dma_tx_we          (dma_tx_we),
        .dma_tx_wdata       (dma_tx_wdata),
        .dma_tx_walmostfull (dma_tx_walmostfull),
        .dma_rx_wvalid      (dma_rx_wvalid),
        .busy               (busy),
        .owner              (owner),
        .err_stray_we       (err_stray_we)
`ifdef GLM_WRARB_PERF_EN
        ,
        .perf_grants        (perf_grants),
        .perf_wait          (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event counters sampled mid-cycle.
    int           tx_cnt    = 0;
    int           start_cnt = 0;
    int           grant_cnt = 0;
    int           gwb_cnt   = 0;
    int           busy_cnt  = 0;
    int           wack0_cnt = 0;
    int           wack1_cnt = 0;
    logic [511:0] tx_last   = '0;

    always @(negedge clk) begin
        if (dma_tx_we) begin
            tx_cnt  <= tx_cnt + 1;
            tx_last <= dma_tx_wdata;
        end
        if (dma_start)               start_cnt <= start_cnt + 1;
        if (req_grant != '0)         grant_cnt <= grant_cnt + 1;
        if (req_grant != '0 && busy) gwb_cnt   <= gwb_cnt + 1;
        if (busy)                    busy_cnt  <= busy_cnt + 1;
        if (req_wack[0])             wack0_cnt <= wack0_cnt + 1;
        if (req_wack[1])             wack1_cnt <= wack1_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [CLADDR_W-1:0] a, input logic [31:0] l);
        req_addr[r*CLADDR_W +: CLADDR_W] = a;
        req_len[r*32 +: 32]              = l;
    endtask

    // Returns at the negedge of the grant cycle.
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_grant != '0) begin
                idx = (req_grant == 2'b10) ? 1 : 0;
                break;
            end
        end
        if (idx < 0) begin
            check("grant_timeout", 64'd0, 64'd1);
            idx = 0;
        end
    endtask

    // Called one tick after the grant (in STREAM); returns in RELEASE.
    task automatic stream(input int r, input int n_we, input int n_ack, input logic [511:0] base);
        for (int i = 0; i < n_we; i++) begin
            req_we[r] = 1'b1;
            req_wdata[r*512 +: 512] = base + 512'(i);
            tick;
        end
        req_we = '0;
        for (int i = 0; i < n_ack; i++) begin
            dma_rx_wvalid = 1'b1;
            tick;
        end
        dma_rx_wvalid = 1'b0;
    endtask

    int g;
    int t0;
    int w0;
    int w1;
    int s0;
    int b0;
    int gc;

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_len = '0;
        req_we = '0;
        req_wdata = '0;
        dma_active = 1'b0;
        dma_tx_walmostfull = 1'b0;
        dma_rx_wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_grant", 64'(req_grant), 64'd0);
        check("rst_start", 64'(dma_start), 64'd0);
        check("rst_tx_we", 64'(dma_tx_we), 64'd0);
        check("rst_addr", 64'(dma_addr), 64'd0);
        check("rst_len", 64'(dma_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_err", 64'(err_stray_we), 64'd0);
        check("rst_wafull", 64'(req_walmostfull), 64'h3);
        check("rst_wack", 64'(req_wack), 64'd0);

        // Single request, len 4
        set_req(0, 42'h100, 32'd4);
        req_valid = 2'b01;
        wait_grant(g);
        check("t1_gidx", 64'(g), 64'd0);
        check("t1_grant", 64'(req_grant), 64'h1);
        check("t1_start", 64'(dma_start), 64'd1);
        check("t1_addr", 64'(dma_addr), 64'h100);
        check("t1_len", 64'(dma_len), 64'd4);
        tick;
        req_valid = '0;
        check("t1_busy", 64'(busy), 64'd1);
        t0 = tx_cnt;
        w0 = wack0_cnt;
        stream(0, 4, 4, 512'hA0);
        check("t1_busy_rel", 64'(busy), 64'd0);
        check("t1_owner", 64'(owner), 64'd0);
        tick;
        check("t1_tx_cnt", 64'(tx_cnt - t0), 64'd4);
        check("t1_wack0", 64'(wack0_cnt - w0), 64'd4);
        check("t1_last_data", tx_last[63:0], 64'hA3);

        // Zero length on requester 1
        set_req(1, 42'h180, 32'd0);
        req_valid = 2'b10;
        s0 = start_cnt;
        b0 = busy_cnt;
        wait_grant(g);
        check("t3_gidx", 64'(g), 64'd1);
        check("t3_start", 64'(dma_start), 64'd0);
        tick;
        req_valid = '0;
        repeat (3) tick;
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_busy_cnt", 64'(busy_cnt - b0), 64'd0);
        check("t3_start_cnt", 64'(start_cnt - s0), 64'd0);

        // Contention, both held, len 2 each
        set_req(0, 42'h200, 32'd2);
        set_req(1, 42'h300, 32'd2);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_grant(g);
            check("t2_order", 64'(g), 64'(t % 2));
            check("t2_addr", 64'(dma_addr), (t % 2 == 1) ? 64'h300 : 64'h200);
            tick;
            stream(g, 2, 2, 512'h200 + 512'(t * 16));
            tick;
        end
        req_valid = '0;
        check("t2_grant_busy", 64'(gwb_cnt), 64'd0);

        // Backpressure routing and dma_active hold-off
        set_req(0, 42'h400, 32'd1);
        req_valid = 2'b01;
        wait_grant(g);
        tick;
        req_valid = '0;
        dma_tx_walmostfull = 1'b1;
        #1 check("t4_wafull_hi", 64'(req_walmostfull), 64'h3);
        dma_tx_walmostfull = 1'b0;
        #1 check("t4_wafull_lo", 64'(req_walmostfull), 64'h2);
        w0 = wack0_cnt;
        w1 = wack1_cnt;
        stream(0, 1, 1, 512'h400);
        tick;
        check("t4_wack0", 64'(wack0_cnt - w0), 64'd1);
        check("t4_wack1", 64'(wack1_cnt - w1), 64'd0);
        check("t4_wafull_idle", 64'(req_walmostfull), 64'h3);
        dma_active = 1'b1;
        set_req(1, 42'h480, 32'd1);
        req_valid = 2'b10;
        gc = grant_cnt;
        repeat (6) tick;
        check("t4_no_grant_active", 64'(grant_cnt - gc), 64'd0);
        dma_active = 1'b0;
        wait_grant(g);
        check("t4_gidx", 64'(g), 64'd1);
        tick;
        req_valid = '0;
        stream(1, 1, 1, 512'h480);
        tick;

        // Write beyond len
        set_req(0, 42'h500, 32'd4);
        req_valid = 2'b01;
        wait_grant(g);
        tick;
        req_valid = '0;
        check("t5a_err_pre", 64'(err_stray_we), 64'd0);
        t0 = tx_cnt;
        stream(0, 5, 4, 512'h500);
        tick;
        check("t5a_tx_cnt", 64'(tx_cnt - t0), 64'd4);
        check("t5a_err", 64'(err_stray_we), 64'd1);
        repeat (3) tick;
        check("t5a_sticky", 64'(err_stray_we), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("t5a_err_clr", 64'(err_stray_we), 64'd0);

        // Stray strobe from a non-owner
        set_req(0, 42'h600, 32'd2);
        req_valid = 2'b01;
        wait_grant(g);
        tick;
        req_valid = '0;
        t0 = tx_cnt;
        req_we = 2'b10;
        req_wdata[512 +: 512] = 512'hDEAD;
        tick;
        req_we = '0;
        tick;
        tick;
        check("t5b_err", 64'(err_stray_we), 64'd1);
        check("t5b_tx_none", 64'(tx_cnt - t0), 64'd0);
        stream(0, 2, 2, 512'h600);
        tick;
        check("t5b_tx_cnt", 64'(tx_cnt - t0), 64'd2);
        check("t5b_last_data", tx_last[63:0], 64'h601);

        // Reset mid-STREAM on requester 1
        set_req(1, 42'h700, 32'd4);
        req_valid = 2'b10;
        wait_grant(g);
        check("t6_gidx", 64'(g), 64'd1);
        tick;
        req_valid = '0;
        req_we = 2'b10;
        req_wdata[512 +: 512] = 512'h700;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_owner", 64'(owner), 64'd0);
        check("t6_err", 64'(err_stray_we), 64'd0);
        t0 = tx_cnt;
        repeat (3) tick;
        check("t6_no_tx", 64'(tx_cnt - t0), 64'd0);
        check("t6_tx_we", 64'(dma_tx_we), 64'd0);
        req_we = '0;
        set_req(0, 42'h800, 32'd1);
        set_req(1, 42'h880, 32'd1);
        req_valid = 2'b11;
        wait_grant(g);
        check("t6_rr0", 64'(g), 64'd0);
        check("t6_addr", 64'(dma_addr), 64'h800);
        tick;
        req_valid = '0;
        t0 = tx_cnt;
        stream(0, 1, 1, 512'h800);
        tick;
        check("t6_tx_after", 64'(tx_cnt - t0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glm_dma_write_arbiter.md
Name: glm_dma_write_arbiter

Overview:
Shares the single DMA write channel (control plus write data plus write-ack) between NUM_REQ write-back requesters. Arbitration is round-robin at whole-transaction granularity. The channel is held by one owner from grant until every line of its transaction is acknowledged, so acks route unambiguously. Sits between the GLM write-back/store units and the DMA write engine.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
CLADDR_W, 42, cache-line address width
OWN_W, $clog2(NUM_REQ) (min 1), owner index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i wants a write transaction; held until granted
req_addr  in  NUM_REQ*CLADDR_W  start line address per requester
req_len  in  NUM_REQ*32  line count per requester
req_grant  out  NUM_REQ  one-cycle pulse: request i accepted
req_we  in  NUM_REQ  write strobe per requester
req_wdata  in  NUM_REQ*512  write line per requester
req_walmostfull  out  NUM_REQ  per-requester backpressure
req_wack  out  NUM_REQ  per-requester write acknowledge
dma_start  out  1  DMA start pulse
dma_addr  out  CLADDR_W  DMA start address
dma_len  out  32  DMA line count
dma_active  in  1  DMA engine busy
dma_tx_we  out  1  DMA write strobe
dma_tx_wdata  out  512  DMA write line
dma_tx_walmostfull  in  1  DMA backpressure
dma_rx_wvalid  in  1  DMA write ack (one per line)
busy  out  1  arbiter holds the channel
owner  out  OWN_W  current or last owner index
err_stray_we  out  1  sticky: write strobe from a non-owner, or a write beyond len

Behaviour:
- Reset values:
  - req_grant=0, dma_start=0, dma_tx_we=0, dma_addr=0, dma_len=0, busy=0, owner=0, err_stray_we=0.
  - Round-robin pointer rr=0; counters sent=0, acked=0.
- States:
  - IDLE: if any req_valid and !dma_active, pick the first set bit scanning rr, rr+1, ... with wrap. Latch owner, addr, len. Go to GRANT.
  - GRANT (one cycle):
    - Always pulse req_grant[owner].
    - If len==0: no dma_start; set rr=owner+1 (mod NUM_REQ); go to IDLE.
    - Else: pulse dma_start with dma_addr/dma_len; busy=1; go to STREAM.
  - STREAM:
    - dma_tx_we/dma_tx_wdata are req_we[owner]/req_wdata[owner] registered, one cycle latency.
    - sent increments per forwarded line.
    - A strobe once sent==len is dropped and sets err_stray_we.
    - A req_we[j] with j!=owner is dropped and sets err_stray_we.
    - On each dma_rx_wvalid, acked increments. When acked reaches len (same-cycle last send and ack allowed), go to RELEASE.
  - RELEASE (one cycle): busy=0; rr=owner+1 (mod NUM_REQ); go to IDLE. Earliest next grant is two cycles after the last ack.
- Backpressure and ack routing:
  - req_walmostfull[owner] = dma_tx_walmostfull while in STREAM (combinational).
  - Every other bit, and all bits outside STREAM, read 1.
  - req_wack[owner] = dma_rx_wvalid while in STREAM (combinational); 0 otherwise.
- Widths and counting:
  - sent and acked are 32-bit; len up to 2^32-1.
  - An ack arriving outside STREAM is ignored.
- req_valid dropping before grant is permitted; the request is simply not selected.
- Reset mid-transaction returns to IDLE with all reset values. The DMA engine is not aborted; it is reset by its own reset.

Optional Feature:
GLM_WRARB_PERF_EN
- Defined: adds output perf_grants (NUM_REQ*32), counting completed grants per requester.
- Also adds perf_wait (NUM_REQ*32), counting cycles req_valid[i]=1 and i not owner.
- Both are free-running, wrap at 2^32, and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single request: req_valid[0]=1, addr=0x100, len=4, four strobes, four acks.
   - Expect req_grant[0] and dma_start in the same cycle, dma_addr=0x100, dma_len=4, 4 dma_tx_we, 4 req_wack[0].
   - busy drops in RELEASE.
2. Contention: req_valid=2'b11 held, both len=2.
   - Expect grant order 0,1,0,1 over four transactions; no grant while busy=1.
3. Zero length: req_valid[1]=1, len=0.
   - Expect req_grant[1] pulse, no dma_start, busy stays 0, next grant goes to requester 0 first.
4. Backpressure: dma_tx_walmostfull=1 during STREAM.
   - Expect req_walmostfull[owner]=1 and non-owner bits=1.
   - With dma_active=1 in IDLE, expect no grant until it drops.
5. Errors: req_we[1] pulses while owner=0; then a 5th strobe with len=4.
   - Expect dma_tx_we unaffected in both cases and err_stray_we=1 sticky until reset.
6. Reset mid-STREAM after 2 of 4 lines.
   - Expect busy=0, owner=0, rr=0, no further dma_tx_we.
   - A new request is granted normally afterwards.
